// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer
//   Frame-level UART transmitter that owns an external timer_input baud
//   generator. A byte is accepted over a valid/ready handshake. The divisor
//   is latched into timer_final at acceptance. timer_enable is held high for
//   the whole frame, and the frame advances one bit per timer_done pulse:
//   start, DATA_BITS data bits LSB first, optional even parity, then stop.
//
//   Handshake: a byte transfers on a rising clk edge where tx_valid and
//   tx_ready are both high. tx_ready is high only while the sequencer is
//   idle. tx_valid while busy is ignored and the byte is not consumed.
//
//   Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
//   between the last data bit and the stop bit.
//
// Parameters
//   BITS       width of baud_div / timer_final
//   DATA_BITS  data bits per frame (5..9)
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   baud_div        bit period minus one, in clocks
//   tx_valid/ready  byte handshake
//   tx_data         byte to send, LSB first
//   tx              serial line, idle high
//   busy            frame in progress
//   frame_done      one-cycle pulse after the stop bit completes
//   timer_enable    to timer enable
//   timer_final     to timer FINAL_VALUE
//   timer_done      from timer done
//   dbg_state       current FSM state encoding
module uart_tx_sequencer #(
  parameter int BITS      = 11,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BITS-1:0]      baud_div,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 timer_enable,
  output logic [BITS-1:0]      timer_final,
  input  logic                 timer_done,
  output logic [2:0]           dbg_state
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BITS-1:0]       timer_final_q, timer_final_d;
  logic                  tx_q, tx_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  timer_enable_q, timer_enable_d;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  // Next-state logic. Every output is decoded from the next state, so each
  // output flop already shows the level of the bit that starts at this edge.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    idx_d         = idx_q;
    timer_final_d = timer_final_q;
    frame_done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d      = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        // timer_done is ignored here; only a handshake leaves IDLE.
        if (tx_valid && tx_ready_q) begin
          shift_d       = tx_data;
          timer_final_d = baud_div;
          state_d       = S_START;
`ifdef UART_TX_PARITY_EN
          parity_d      = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (timer_done) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (timer_done) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (timer_done) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (timer_done) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase

    // Leaving STOP always passes through one IDLE cycle with the timer
    // disabled, which clears the timer count before the next frame.
    busy_d         = (state_d != S_IDLE);
    timer_enable_d = (state_d != S_IDLE);
    tx_ready_d     = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      shift_q        <= '0;
      idx_q          <= '0;
      timer_final_q  <= '0;
      tx_q           <= 1'b1;
      tx_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      timer_enable_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      idx_q          <= idx_d;
      timer_final_q  <= timer_final_d;
      tx_q           <= tx_d;
      tx_ready_q     <= tx_ready_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      timer_enable_q <= timer_enable_d;
`ifdef UART_TX_PARITY_EN
      parity_q       <= parity_d;
`endif
    end
  end

  assign tx           = tx_q;
  assign tx_ready     = tx_ready_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign timer_enable = timer_enable_q;
  assign timer_final  = timer_final_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer. Provides a timer_input-style baud timer,
// a frame-level reference model (per-cycle expected tx levels in a queue),
// a compare process running every cycle, and directed scenarios with
// hand-computed literal expectations.
module tb_uart_tx_sequencer;

  localparam int BITS      = 11;
  localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FB = DATA_BITS + 3;
`else
  localparam int FB = DATA_BITS + 2;
`endif

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [BITS-1:0]      baud_div = 11'd3;
  logic                 tx_valid = 1'b0;
  logic [DATA_BITS-1:0] tx_data = '0;
  logic                 tx_ready, tx, busy, frame_done, timer_enable;
  logic [BITS-1:0]      timer_final;
  logic                 timer_done;
  logic [2:0]           dbg_state;

  always #5 clk = ~clk;

  uart_tx_sequencer #(.BITS(BITS), .DATA_BITS(DATA_BITS)) dut (
    .clk(clk), .reset(reset), .baud_div(baud_div), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .tx(tx), .busy(busy),
    .frame_done(frame_done), .timer_enable(timer_enable),
    .timer_final(timer_final), .timer_done(timer_done), .dbg_state(dbg_state)
  );

  // ---------------- baud timer environment ----------------
  logic [BITS-1:0] tq = '0;
  logic            inject_done = 1'b0;

  always @(posedge clk) begin
    if (timer_enable !== 1'b1)    tq <= '0;
    else if (tq == timer_final)   tq <= '0;
    else                          tq <= tq + 1'b1;
  end

  assign timer_done = ((timer_enable === 1'b1) && (tq == timer_final)) || inject_done;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [0:0]      exp_q[$];       // expected tx level for each remaining frame cycle
  logic            m_init  = 1'b0;
  logic            m_ready = 1'b0;
  logic            m_fd    = 1'b0;
  logic [BITS-1:0] m_final = '0;
  int              m_accepts = 0;
  longint          cyc = 0;
  longint          acc_cyc[$];

  task automatic push_frame(input logic [DATA_BITS-1:0] d, input int b);
    logic [0:0] bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^d);
`endif
    bits.push_back(1'b1);
    foreach (bits[i])
      for (int k = 0; k <= b; k++) exp_q.push_back(bits[i]);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      exp_q.delete();
      m_ready = 1'b0;
      m_fd    = 1'b0;
      m_final = '0;
      m_init  = 1'b1;
    end else begin
      m_fd = 1'b0;
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_fd    = 1'b1;
          m_ready = 1'b1;
        end
      end else if (m_ready && tx_valid) begin
        push_frame(tx_data, int'(baud_div));
        m_final = baud_div;
        m_ready = 1'b0;
        m_accepts++;
        acc_cyc.push_back(cyc);
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (m_init) begin
      if (exp_q.size() > 0) begin
        check("tx", tx, exp_q[0]);
        check("busy", busy, 1);
        check("timer_enable", timer_enable, 1);
        check("tx_ready", tx_ready, 0);
        check("frame_done", frame_done, 0);
      end else begin
        check("tx_idle", tx, 1);
        check("busy_idle", busy, 0);
        check("timer_enable_idle", timer_enable, 0);
        check("tx_ready_idle", tx_ready, m_ready);
        check("frame_done_idle", frame_done, m_fd);
      end
      check("timer_final", timer_final, m_final);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int limit);
    int n = 0;
    while (!(m_ready && exp_q.size() == 0)) begin
      @(posedge clk); #1;
      n++;
      if (n > limit) begin
        check("wait_ready_timeout", 0, 1);
        break;
      end
    end
  endtask

  // Returns 1 time unit after the acceptance edge.
  task automatic send(input logic [DATA_BITS-1:0] d);
    wait_ready(30000);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  // Counts negedges after acceptance until frame_done is seen.
  task automatic count_to_done(input int limit, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_done !== 1'b1 && k < limit);
  endtask

  // ---------------- directed scenarios ----------------
  logic [10:0] lit_a5;
  int k, a0, g;
  logic expb;

  initial begin
`ifdef UART_TX_PARITY_EN
    lit_a5 = 11'b10101001010;
`else
    lit_a5 = 11'b01101001010;
`endif

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_tx_ready", tx_ready, 0);
    check("reset_tx", tx, 1);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_tx_ready", tx_ready, 1);
    check("post_reset_tx", tx, 1);
    check("post_reset_busy", busy, 0);
    check("post_reset_timer_enable", timer_enable, 0);
    check("post_reset_timer_final", timer_final, 0);

    // Single byte 0xA5, 4-clock bits
    baud_div = 11'd3;
    send(8'hA5);
    check("a5_model_len", exp_q.size(), FB * 4);
    for (int i = 0; i < FB * 4; i++) begin
      @(negedge clk);
      check("a5_bit", tx, lit_a5[i / 4]);
    end
    @(negedge clk);
    check("a5_frame_done", frame_done, 1);

    // Divisor latch: change baud_div mid-frame
    baud_div = 11'd1735;
    send(8'h55);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 100) baud_div = 11'd3;
      if (k == 5000) check("latch_timer_final", timer_final, 1735);
    end while (frame_done !== 1'b1 && k < 40000);
    check("latch_frame_len", k, FB * 1736 + 1);
    send(8'h0F);
    @(negedge clk);
    check("latch_next_final", timer_final, 3);
    count_to_done(200, k);
    check("latch_next_len", k, FB * 4);

    // Back-to-back with tx_valid held high
    baud_div = 11'd2;
    wait_ready(200);
    a0 = m_accepts;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    g = 0;
    while (m_accepts < a0 + 1 && g < 200) begin @(posedge clk); #1; g++; end
    tx_data = 8'hFF;
    g = 0;
    while (m_accepts < a0 + 2 && g < 200) begin @(posedge clk); #1; g++; end
    tx_valid = 1'b0;
    check("b2b_accepts", m_accepts, a0 + 2);
    check("b2b_gap", int'(acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2]), FB * 3 + 1);
    for (int i = 0; i < FB * 3; i++) begin
      int j;
      j = i / 3;
      expb = (j == 0) ? 1'b0 : 1'b1;
`ifdef UART_TX_PARITY_EN
      if (j == DATA_BITS + 1) expb = 1'b0;
`endif
      @(negedge clk);
      check("b2b_ff_bit", tx, expb);
    end

    // Reset during DATA bit 3
    baud_div = 11'd3;
    send(8'h96);
    repeat (17) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_tx", tx, 1);
    check("midreset_busy", busy, 0);
    check("midreset_timer_enable", timer_enable, 0);
    check("midreset_frame_done", frame_done, 0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("midreset_no_done", frame_done, 0);
    end

    // Ignored tx_valid during START, timer_done pulses in IDLE
    send(8'h81);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data  = '0;
    count_to_done(200, k);
    check("ignored_frame_len", k, FB * 4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("ignored_not_sent", busy, 0);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 inject_done = 1'b1;
      @(posedge clk); #1 inject_done = 1'b0;
    end
    @(negedge clk);
    check("inject_busy", busy, 0);
    check("inject_tx_ready", tx_ready, 1);
    check("inject_state", dbg_state, 0);

    // baud_div = 0 gives 1-clock bits
    baud_div = 11'd0;
    send(8'h5A);
    count_to_done(100, k);
    check("baud0_frame_len", k, FB + 1);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_sequencer.md
# uart_tx_sequencer

Frame-level UART transmit controller that owns and sequences the `timer_input` baud generator. It accepts bytes over a valid/ready handshake, programs the timer's `FINAL_VALUE` from a latched divisor, gates the timer `enable`, and advances start/data/(parity)/stop bits on each timer `done` pulse. It sits between the host-side byte source and the serial `tx` pin; it is the sole driver of its timer instance.

## Interface
- `BITS`, 11: width of the baud divisor and timer `FINAL_VALUE`.
- `DATA_BITS`, 8: data bits per frame, 5..9.

- `clk` in 1: system clock (50 MHz nominal).
- `reset` in 1: synchronous, active-high reset.
- `baud_div` in BITS: bit period minus one, in clocks (1735 for 28.8 kbaud at 50 MHz).
- `tx_valid` in 1: byte available.
- `tx_data` in DATA_BITS: byte to send, LSB transmitted first.
- `tx_ready` out 1: sequencer can accept a byte this cycle.
- `tx` out 1: serial line, idle high.
- `busy` out 1: a frame is in progress.
- `frame_done` out 1: one-cycle pulse when the stop bit completes.
- `timer_enable` out 1: to timer `enable`.
- `timer_final` out BITS: to timer `FINAL_VALUE`.
- `timer_done` in 1: from timer `done`.

## Operation
- Timer contract: while `timer_enable` is high, `timer_done` pulses every `timer_final`+1 clocks, first pulse `timer_final` clocks after enable rises. `timer_enable` low clears the timer count.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE: `tx`=1, `tx_ready`=1, `busy`=0, `timer_enable`=0. On `tx_valid && tx_ready`, latch `tx_data` into the shift register and `baud_div` into `timer_final`. Go to START.
- START: `tx`=0. On `timer_done`, go to DATA with bit index 0.
- DATA: `tx`=shift[0]. On `timer_done`, shift right and increment the index. After the done for index `DATA_BITS`-1, go to PARITY if compiled in, else STOP.
- PARITY: `tx`=parity bit. On `timer_done`, go to STOP.
- STOP: `tx`=1. On `timer_done`, pulse `frame_done` and go to IDLE.
- `timer_enable`=1 and `busy`=1 in every non-IDLE state. `tx_ready`=1 only in IDLE.
- `timer_final` changes only at acceptance. `baud_div` changes mid-frame have no effect until the next frame.
- `timer_done` in IDLE is ignored. `tx_valid` outside IDLE is ignored and the data is not consumed.
- `baud_div`=0 is legal and gives 1-clock bits.

## Timing
- Reset values: `tx`=1, `tx_ready`=0 while `reset` is high and 1 from the first cycle after, `busy`=0, `frame_done`=0, `timer_enable`=0, `timer_final`=0, FSM in IDLE.
- Reset mid-frame: the next edge returns all outputs to their reset values, the frame is abandoned, and no `frame_done` is issued.
- Acceptance at edge N: `tx` falls, `busy` and `timer_enable` rise, and `tx_ready` falls, all visible after edge N.
- Each bit lasts exactly `baud_div`+1 clocks.
- Frame length is (2+`DATA_BITS`[+1])·(`baud_div`+1) clocks.
- `frame_done` is asserted in the cycle after the final `timer_done`, together with the return to IDLE.
- Back-to-back frames: at least one IDLE cycle between frames, with `timer_enable` low, which clears the timer. The next start bit can begin one cycle after `frame_done`.
- All outputs are registered.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state follows DATA.
  - Parity bit = XOR of all data bits (even parity).
  - Frame is `DATA_BITS`+3 bits long.
- `UART_TX_PARITY_EN` undefined: no PARITY state and no parity logic. Frame is `DATA_BITS`+2 bits long.

## Test plan
- Reset then idle: hold `reset` 2 cycles, release. Expect `tx`=1, `busy`=0, `timer_enable`=0, and `tx_ready`=1 on the first post-reset cycle.
- Single byte: `baud_div`=3, send 0xA5. Expect `tx` = 0,1,0,1,0,0,1,0,1,1, each level held exactly 4 clocks. Expect `frame_done` 40 clocks after acceptance (44 clocks with parity, parity bit 0).
- Divisor latch: `baud_div`=1735, accept 0x55, then change `baud_div` to 3 mid-frame. Every bit of the current frame stays 1736 clocks. The next frame uses 4-clock bits.
- Back-to-back: hold `tx_valid` high with 0x00 then 0xFF. Expect exactly one IDLE cycle between frames and `timer_enable` low in that cycle. Expect the second frame's bits to be 0x FF LSB-first.
- Reset mid-frame: assert `reset` during DATA bit 3. One edge later expect `tx`=1, `busy`=0, `timer_enable`=0 and no `frame_done`.
- Ignored stimulus: pulse `tx_valid` with 0x3C during START. Expect the current frame unchanged and 0x3C not sent afterwards unless re-presented. Expect `timer_done` pulses injected in IDLE to leave the FSM in IDLE.
